// File: rtl/serial_subtractor.sv
// Bit-serial a - b over WIDTH cycles, LSB first, with a three-state IDLE/RUN/DONE FSM.
// Optional signed-overflow output ovf is built only when SUB_OVF_EN is defined.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic             bout_q;
  logic             done_q;
  logic             d_d;
  logic             br_d;
`ifdef SUB_OVF_EN
  logic             sa_q;
  logic             sb_q;
  logic             ovf_q;
`endif

  // One full-subtractor slice on the current LSBs of the operand shifters.
  always_comb begin
    d_d  = a_q[0] ^ b_q[0] ^ br_q;
    br_d = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SUB_OVF_EN
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SUB_OVF_EN
            sa_q    <= a[WIDTH-1];
            sb_q    <= b[WIDTH-1];
            ovf_q   <= 1'b0;
`endif
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          br_q   <= br_d;
          diff_q <= {d_d, diff_q[WIDTH-1:1]};
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          // Flags are registered here, so done/bout become visible as the FSM returns to IDLE.
          done_q  <= 1'b1;
          bout_q  <= br_q;
`ifdef SUB_OVF_EN
          ovf_q   <= (sa_q != sb_q) && (diff_q[WIDTH-1] != sa_q);
`endif
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
